// File: rtl/riscv_ctrl_pkg.sv
// Shared types and defaults for the run-control / performance-monitor block.
package riscv_ctrl_pkg;
  // DONE is reported with the DRAIN code; done_o tells them apart.
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, DRAIN = 2'd3} estado_t;
  typedef enum logic [1:0] {CAUSA_NONE = 2'd0, CAUSA_HALT = 2'd1, CAUSA_ZERO = 2'd2, CAUSA_WDOG = 2'd3} causa_t;

  localparam logic [4:0]  HALT_REG_DEF = 5'd10;
  localparam logic [31:0] HALT_VAL_DEF = 32'h1;
  localparam int          DRAIN_W      = 8;
endpackage

// File: rtl/ctrl_ejecucion_contador_sat.sv
// Saturating up-counter: synchronous clear, increments while inc=1, holds at all-ones.
module contador_sat #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/ctrl_ejecucion.sv
// Run control for the pipelined core: reset/enable sequencing, end-of-program detection, perf counters.
// Optional watchdog end condition is compiled in with CTRL_WATCHDOG_EN.
module ctrl_ejecucion
  import riscv_ctrl_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter logic [4:0]  HALT_REG  = HALT_REG_DEF,
  parameter logic [31:0] HALT_VAL  = HALT_VAL_DEF,
  parameter int          DRAIN_CYC = 4,
  parameter int          WDOG_CYC  = 100000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [31:0]      instr_f_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             regwrite_w_i,
  input  logic [4:0]       dir_reg_w_i,
  input  logic [31:0]      resultado_w_i,
  output logic             core_reset_o,
  output logic             core_en_o,
  output logic [1:0]       estado_o,
  output logic             done_o,
  output logic [1:0]       halt_cause_o,
  output logic [CNT_W-1:0] ciclos_o,
  output logic [CNT_W-1:0] instr_o,
  output logic [CNT_W-1:0] stalls_o,
  output logic [CNT_W-1:0] flushes_o
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state, state_nx;
  logic [DRAIN_W-1:0] dcnt, dcnt_nx;
  causa_t             causa, causa_nx;
  logic               activo, arrancar, halt_wr, zero_f, wdog_hit;

  assign activo   = (state == S_RUN) || (state == S_DRAIN);
  assign arrancar = start_i && ((state == S_IDLE) || (state == S_DONE));
  assign halt_wr  = regwrite_w_i && (dir_reg_w_i == HALT_REG) && (resultado_w_i == HALT_VAL);
  // A zero word fetched while stalled or flushed is a bubble, not the end of the program.
  assign zero_f   = (instr_f_i == 32'h0) && !stall_i && !flush_i;

`ifdef CTRL_WATCHDOG_EN
  // Fires on the cycle whose count brings ciclos_o up to WDOG_CYC.
  assign wdog_hit = (64'(ciclos_o) >= 64'(WDOG_CYC - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    causa_nx = causa;
    case (state)
      S_IDLE, S_DONE: if (start_i) begin
        state_nx = S_CLEAR;
        causa_nx = CAUSA_NONE;
      end
      S_CLEAR: state_nx = S_RUN;
      S_RUN: begin
        if (halt_wr) begin
          state_nx = S_DONE;
          causa_nx = CAUSA_HALT;
        end else if (wdog_hit) begin
          state_nx = S_DONE;
          causa_nx = CAUSA_WDOG;
        end else if (zero_f) begin
          state_nx = S_DRAIN;
          dcnt_nx  = DRAIN_W'(DRAIN_CYC - 1);
        end
      end
      S_DRAIN: begin
        if (halt_wr) begin
          state_nx = S_DONE;
          causa_nx = CAUSA_HALT;
        end else if (wdog_hit) begin
          state_nx = S_DONE;
          causa_nx = CAUSA_WDOG;
        end else if (dcnt == '0) begin
          state_nx = S_DONE;
          causa_nx = CAUSA_ZERO;
        end else begin
          dcnt_nx = dcnt - DRAIN_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= S_IDLE;
      dcnt  <= '0;
      causa <= CAUSA_NONE;
    end else begin
      state <= state_nx;
      dcnt  <= dcnt_nx;
      causa <= causa_nx;
    end
  end

  // Counters clear on entry to CLEAR so they already read zero during that cycle.
  contador_sat #(.CNT_W(CNT_W)) u_ciclos (
    .clk(clk_i), .rst(reset_i), .clr(arrancar), .inc(activo), .cnt(ciclos_o));
  contador_sat #(.CNT_W(CNT_W)) u_instr (
    .clk(clk_i), .rst(reset_i), .clr(arrancar), .inc(activo && retire_i), .cnt(instr_o));
  contador_sat #(.CNT_W(CNT_W)) u_stalls (
    .clk(clk_i), .rst(reset_i), .clr(arrancar), .inc(activo && stall_i), .cnt(stalls_o));
  contador_sat #(.CNT_W(CNT_W)) u_flushes (
    .clk(clk_i), .rst(reset_i), .clr(arrancar), .inc(activo && flush_i), .cnt(flushes_o));

  assign core_reset_o = (state == S_IDLE) || (state == S_CLEAR);
  assign core_en_o    = activo;
  assign done_o       = (state == S_DONE);
  assign halt_cause_o = causa;
  assign estado_o     = (state == S_DONE) ? DRAIN : state[1:0];
endmodule

// File: tb/tb_ctrl_ejecucion.sv
// Self-checking bench for ctrl_ejecucion: per-run scoreboard of final counters and halt cause.
module tb_ctrl_ejecucion;
  localparam int DRAIN_CYC = 4;
`ifdef CTRL_WATCHDOG_EN
  localparam int WD = 50;
`else
  localparam int WD = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] instr_f_i = 32'h13;
  logic        stall_i = 1'b0, flush_i = 1'b0, retire_i = 1'b0, regwrite_w_i = 1'b0;
  logic [4:0]  dir_reg_w_i = 5'd0;
  logic [31:0] resultado_w_i = 32'd0;

  logic        core_reset_o, core_en_o, done_o;
  logic [1:0]  estado_o, halt_cause_o;
  logic [31:0] ciclos_o, instr_o, stalls_o, flushes_o;

  logic        core_reset_s, core_en_s, done_s;
  logic [1:0]  estado_s, halt_cause_s;
  logic [3:0]  ciclos_s, instr_s, stalls_s, flushes_s;

  always #5 clk = ~clk;

  ctrl_ejecucion #(.CNT_W(32), .DRAIN_CYC(DRAIN_CYC), .WDOG_CYC(50)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .instr_f_i(instr_f_i),
    .stall_i(stall_i), .flush_i(flush_i), .retire_i(retire_i), .regwrite_w_i(regwrite_w_i),
    .dir_reg_w_i(dir_reg_w_i), .resultado_w_i(resultado_w_i),
    .core_reset_o(core_reset_o), .core_en_o(core_en_o), .estado_o(estado_o), .done_o(done_o),
    .halt_cause_o(halt_cause_o), .ciclos_o(ciclos_o), .instr_o(instr_o),
    .stalls_o(stalls_o), .flushes_o(flushes_o));

  ctrl_ejecucion #(.CNT_W(4), .DRAIN_CYC(DRAIN_CYC), .WDOG_CYC(50)) dut_s (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .instr_f_i(instr_f_i),
    .stall_i(stall_i), .flush_i(flush_i), .retire_i(retire_i), .regwrite_w_i(regwrite_w_i),
    .dir_reg_w_i(dir_reg_w_i), .resultado_w_i(resultado_w_i),
    .core_reset_o(core_reset_s), .core_en_o(core_en_s), .estado_o(estado_s), .done_o(done_s),
    .halt_cause_o(halt_cause_s), .ciclos_o(ciclos_s), .instr_o(instr_s),
    .stalls_o(stalls_s), .flushes_o(flushes_s));

  typedef struct {
    int         ciclos, instr, stalls, flushes;
    logic [1:0] causa;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    start_i = 0; instr_f_i = 32'h13; stall_i = 0; flush_i = 0; retire_i = 0;
    regwrite_w_i = 0; dir_reg_w_i = 0; resultado_w_i = 0;
  endtask

  // One run: start pulse, then a per-cycle program; 0 for an event cycle means "never".
  task automatic run_prog(input int halt_at, input int zero_at, input int st_from, input int st_len,
                          input int fl_at, input int ret_skip, input int max_cyc);
    exp_t e;
    exp_t got;
    int   st, dc;
    e.ciclos = 0; e.instr = 0; e.stalls = 0; e.flushes = 0; e.causa = 2'd0;
    st = 0; dc = 0;
    start_i = 1; @(posedge clk); #1 start_i = 0;
    chk("clear_estado", 32'(estado_o), 32'd1);
    chk("clear_core_reset", 32'(core_reset_o), 32'd1);
    chk("clear_done", 32'(done_o), 32'd0);
    chk("clear_ciclos", ciclos_o, 32'd0);
    @(posedge clk); #1;
    for (int k = 1; k <= max_cyc && st != 2; k++) begin
      logic stl, fl, hw, zf, ret;
      stl = (k >= st_from) && (k < st_from + st_len);
      fl  = (k == fl_at);
      hw  = (k == halt_at);
      ret = (k > ret_skip) && !stl;
      zf  = (k == zero_at) && !stl && !fl;
      instr_f_i = ((k == zero_at) || stl || fl) ? 32'h0 : 32'h00a00513;
      stall_i = stl; flush_i = fl; retire_i = ret;
      start_i = (k == 5);
      if (hw)           begin regwrite_w_i = 1; dir_reg_w_i = 5'd10; resultado_w_i = 32'd1; end
      else if (k == 3)  begin regwrite_w_i = 1; dir_reg_w_i = 5'd10; resultado_w_i = 32'd5; end
      else if (k == 4)  begin regwrite_w_i = 1; dir_reg_w_i = 5'd11; resultado_w_i = 32'd1; end
      else if (k == 6)  begin regwrite_w_i = 0; dir_reg_w_i = 5'd10; resultado_w_i = 32'd1; end
      else              begin regwrite_w_i = 0; dir_reg_w_i = 5'(k); resultado_w_i = 32'(k); end
      e.ciclos++;
      if (ret) e.instr++;
      if (stl) e.stalls++;
      if (fl)  e.flushes++;
      if (hw) begin st = 2; e.causa = 2'd1; end
      else if (WD > 0 && e.ciclos >= WD) begin st = 2; e.causa = 2'd3; end
      else if (st == 0 && zf) begin st = 1; dc = DRAIN_CYC - 1; end
      else if (st == 1) begin
        if (dc == 0) begin st = 2; e.causa = 2'd2; end
        else dc--;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    if (st == 2) begin
      sb.push_back(e);
      chk("done", 32'(done_o), 32'd1);
      chk("done_core_en", 32'(core_en_o), 32'd0);
      chk("done_core_reset", 32'(core_reset_o), 32'd0);
      chk("done_estado", 32'(estado_o), 32'd3);
      // Activity after the end must not move the frozen counters.
      stall_i = 1; flush_i = 1; retire_i = 1;
      repeat (2) @(posedge clk);
      #1 idle_inputs();
      got = sb.pop_front();
      chk("ciclos", ciclos_o, 32'(got.ciclos));
      chk("instr", instr_o, 32'(got.instr));
      chk("stalls", stalls_o, 32'(got.stalls));
      chk("flushes", flushes_o, 32'(got.flushes));
      chk("halt_cause", 32'(halt_cause_o), 32'(got.causa));
    end else begin
      chk("running_estado", 32'(estado_o), 32'd2);
      chk("running_core_en", 32'(core_en_o), 32'd1);
      chk("running_done", 32'(done_o), 32'd0);
      chk("running_ciclos", ciclos_o, 32'(e.ciclos));
    end
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_estado", 32'(estado_o), 32'd0);
    chk("rst_core_reset", 32'(core_reset_o), 32'd1);
    chk("rst_core_en", 32'(core_en_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cause", 32'(halt_cause_o), 32'd0);
    chk("rst_ciclos", ciclos_o, 32'd0);
    @(negedge clk) reset_i = 0;
    repeat (3) @(posedge clk);
    #1 chk("idle_hold", 32'(estado_o), 32'd0);

    run_prog(27, 0, 0, 0, 0, 6, 100);   // halt-write at cycle 27, 21 retires
    run_prog(0, 15, 0, 0, 0, 2, 100);   // zero fetch at 15, drain to 19
    run_prog(30, 0, 10, 3, 20, 2, 100); // zero fetches under stall/flush ignored
    run_prog(12, 10, 0, 0, 0, 2, 100);  // halt-write during drain wins

    // Asynchronous reset in the middle of a run.
    start_i = 1; @(posedge clk); #1 start_i = 0;
    @(posedge clk); #1 retire_i = 1; stall_i = 1;
    repeat (8) @(posedge clk);
    #1 reset_i = 1;
    #1;
    chk("arst_core_reset", 32'(core_reset_o), 32'd1);
    chk("arst_core_en", 32'(core_en_o), 32'd0);
    chk("arst_estado", 32'(estado_o), 32'd0);
    chk("arst_ciclos", ciclos_o, 32'd0);
    chk("arst_instr", instr_o, 32'd0);
    idle_inputs();
    @(negedge clk) reset_i = 0;
    @(posedge clk); #1;

    run_prog(0, 0, 0, 0, 0, 2, 200);    // no end condition
    chk("sat_ciclos", 32'(ciclos_s), 32'd15);
    chk("sat_instr", 32'(instr_s), 32'd15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
